// File: rtl/switch_pkg.sv
// Shared constants for the switch conditioning stage.
// Holds debounce timing presets and the switch-to-taillight bit map.
package switch_pkg;

    // 10 ms at 50 MHz.
    localparam int SW_DEBOUNCE_10MS = 500000;

    // Short debounce window used by benches.
    localparam int SIM_DEBOUNCE = 4;

    localparam int N_SW_DEFAULT = 4;

    // Switch bit assignments seen by the taillight FSM.
    localparam int SW_LEFT   = 0;
    localparam int SW_RIGHT  = 1;
    localparam int SW_HAZARD = 2;
    localparam int SW_BRAKE  = 3;

    // Per-bit debounce classification for the current cycle.
    typedef enum logic [1:0] {
        DB_STABLE  = 2'd0,
        DB_PENDING = 2'd1,
        DB_COMMIT  = 2'd2
    } db_state_e;

    // Counter width for a given debounce window.
    function automatic int db_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, debounce counter,
// clean level register and registered one-cycle rise/fall pulses.
// Ports: clk, rst_n, raw (async in), clean, rise, fall.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE,
    parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    db_state_e        state;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        state   = DB_STABLE;

        if (sync2_q != clean_q) begin
            state = (cnt_q == CNT_MAX) ? DB_COMMIT : DB_PENDING;
        end

        unique case (state)
            DB_STABLE: begin
                cnt_d = '0;
            end
            DB_PENDING: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            DB_COMMIT: begin
                // Counter never passes CNT_MAX, so it cannot wrap.
                cnt_d   = '0;
                clean_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions raw slide switches for the taillight FSM: each bit is
// synchronised and debounced independently, with rise/fall pulses.
// Ports: clk, rst_n, sw_raw[N_SW] in; sw_clean, sw_rise, sw_fall out.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_10MS,
    parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall
);

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_raw[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with a 4-cycle debounce window.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_switch_conditioner;
    import switch_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_clean;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;

    int checks;
    int failures;

    switch_conditioner #(
        .N_SW            (4),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        sw_raw = 4'h0;
        rst_n  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        sw_raw = 4'hF;
        rst_n  = 1'b0;
        #2;
        chk("reset_async_clean", sw_clean, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset_clean", sw_clean, 4'h0);
            chk("reset_rise", sw_rise, 4'h0);
            chk("reset_fall", sw_fall, 4'h0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("rel_early_clean", sw_clean, 4'h0);
            chk("rel_early_rise", sw_rise, 4'h0);
        end
        tick();
        chk("rel_clean", sw_clean, 4'hF);
        chk("rel_rise", sw_rise, 4'hF);
        chk("rel_fall", sw_fall, 4'h0);
        tick();
        chk("rel_rise_end", sw_rise, 4'h0);
        chk("rel_clean_hold", sw_clean, 4'hF);
    endtask

    task automatic test_press();
        apply_reset();
        sw_raw = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("press_early_clean", sw_clean, 4'h0);
            chk("press_early_rise", sw_rise, 4'h0);
        end
        tick();
        chk("press_clean", sw_clean, 4'b0001);
        chk("press_rise", sw_rise, 4'b0001);
        chk("press_fall", sw_fall, 4'h0);
        tick();
        chk("press_rise_end", sw_rise, 4'h0);
        chk("press_clean_hold", sw_clean, 4'b0001);
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            sw_raw = 4'b0010;
            repeat (3) begin
                tick();
                chk("bounce_clean", sw_clean, 4'h0);
                chk("bounce_pulse", sw_rise | sw_fall, 4'h0);
            end
            sw_raw = 4'b0000;
            repeat (2) begin
                tick();
                chk("bounce_clean", sw_clean, 4'h0);
                chk("bounce_pulse", sw_rise | sw_fall, 4'h0);
            end
        end
        repeat (6) begin
            tick();
            chk("settle_clean", sw_clean, 4'h0);
            chk("settle_pulse", sw_rise | sw_fall, 4'h0);
        end
        sw_raw = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bhold_early_clean", sw_clean, 4'h0);
        end
        tick();
        chk("bhold_clean", sw_clean, 4'b0010);
        chk("bhold_rise", sw_rise, 4'b0010);
        tick();
        chk("bhold_rise_end", sw_rise, 4'h0);
    endtask

    task automatic test_release();
        apply_reset();
        sw_raw = 4'b0100;
        repeat (8) tick();
        chk("rls_setup_clean", sw_clean, 4'b0100);
        sw_raw = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rls_early_clean", sw_clean, 4'b0100);
            chk("rls_early_fall", sw_fall, 4'h0);
        end
        tick();
        chk("rls_clean", sw_clean, 4'h0);
        chk("rls_fall", sw_fall, 4'b0100);
        chk("rls_rise", sw_rise, 4'h0);
        tick();
        chk("rls_fall_end", sw_fall, 4'h0);
        chk("rls_rise_end", sw_rise, 4'h0);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        sw_raw = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sim_early_clean", sw_clean, 4'h0);
        end
        tick();
        chk("sim_clean", sw_clean, 4'b1011);
        chk("sim_rise", sw_rise, 4'b1011);
        chk("sim_fall", sw_fall, 4'h0);
        tick();
        chk("sim_rise_end", sw_rise, 4'h0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        sw_raw = 4'b1000;
        // After four edges: sync1, sync2, count 1, count 2.
        repeat (4) tick();
        chk("mid_pre_clean", sw_clean, 4'h0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_clean", sw_clean, 4'h0);
        repeat (3) begin
            tick();
            chk("mid_rst_pulse", sw_rise | sw_fall, 4'h0);
            chk("mid_rst_clean", sw_clean, 4'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_early_clean", sw_clean, 4'h0);
            chk("mid_early_rise", sw_rise, 4'h0);
        end
        tick();
        chk("mid_clean", sw_clean, 4'b1000);
        chk("mid_rise", sw_rise, 4'b1000);
        tick();
        chk("mid_rise_end", sw_rise, 4'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        sw_raw   = 4'h0;
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
